// File: rtl/int_fp_div_pkg.sv
// Shared constants and state encoding for the int8/fp16 iterative divider.
package int_fp_div_pkg;

  localparam int unsigned EXP_W   = 5;
  localparam int unsigned MAN_W   = 10;
  localparam int unsigned INT_W   = 8;
  localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
  localparam int unsigned FP_IT   = MAN_W + 2;
  localparam int unsigned INT_IT  = INT_W;

  // Core datapath widths: partial remainder holds up to the 11-bit fp significand.
  localparam int unsigned REM_W = MAN_W + 1;
  localparam int unsigned QUO_W = FP_IT;
  localparam int unsigned CNT_W = 4;

  localparam logic [FP_W-2:0] FP_INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [FP_W-2:0] FP_ZERO_MAG = '0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV  = 2'd1;
  localparam state_t NORM = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/int_fp_div_restoring_core.sv
// Restoring shift-subtract core: one quotient bit per cycle, done pulses after the last bit.
// INT_FP_DIV_REM_EN exposes the low bits of the final partial remainder.
module div_restoring_core
  import int_fp_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] iters,
  input  logic [REM_W-1:0] num_hi,
  input  logic [QUO_W-1:0] num_lo,
  input  logic [REM_W-1:0] den,
  output logic [QUO_W-1:0] quo,
  output logic             done
`ifdef INT_FP_DIV_REM_EN
  ,
  output logic [INT_W-1:0] rem
`endif
);

  logic [REM_W-1:0] r;
  logic [QUO_W-1:0] dvd;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [REM_W:0]   trial;
  logic             ge;

  assign trial = {r, dvd[QUO_W-1]};
  assign ge    = trial >= {1'b0, den};

`ifdef INT_FP_DIV_REM_EN
  assign rem = r[INT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r    <= '0;
      dvd  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r    <= num_hi;
        dvd  <= num_lo;
        quo  <= '0;
        cnt  <= iters;
        busy <= 1'b1;
      end else if (busy) begin
        r   <= ge ? REM_W'(trial - {1'b0, den}) : REM_W'(trial);
        quo <= {quo[QUO_W-2:0], ge};
        dvd <= {dvd[QUO_W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/int_fp_div.sv
// Iterative divider computing a/b as fp16 (mode=1) or signed int8 (mode=0), valid/ready both sides.
// Optional INT_FP_DIV_REM_EN adds a rem output (int remainder, sign of dividend).
module int_fp_div
  import int_fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        error
`ifdef INT_FP_DIV_REM_EN
  ,
  output logic [15:0] rem
`endif
);

  state_t      state;
  logic        mode_r;
  logic [15:0] a_r, b_r;
  logic        accept;

  logic [INT_W-1:0] ua, ub;
  logic [REM_W-1:0] num_hi, den;
  logic [QUO_W-1:0] num_lo, quo;
  logic [CNT_W-1:0] iters;
  logic             core_done;
`ifdef INT_FP_DIV_REM_EN
  logic [INT_W-1:0] core_rem;
  logic [15:0]      rem_n;
`endif

  logic              s_fp, neg_q;
  logic signed [6:0] e_fp, exp_fp;
  logic [MAN_W-1:0]  frac;
  logic [INT_W-1:0]  q_int;
  logic [15:0]       c_n;
  logic              err_n;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;

  // fp runs the divide on the significands; starting the remainder at ma>>1 with
  // ma[0] shifted in first makes the first trial compare ma against mb (bit 11).
  always_comb begin
    ua = a[7] ? INT_W'(~a[7:0] + 8'd1) : a[7:0];
    ub = b[7] ? INT_W'(~b[7:0] + 8'd1) : b[7:0];
    if (mode) begin
      num_hi = {1'b0, 1'b1, a[MAN_W-1:1]};
      num_lo = {a[0], {(QUO_W-1){1'b0}}};
      den    = {1'b1, b[MAN_W-1:0]};
      iters  = CNT_W'(FP_IT);
    end else begin
      num_hi = '0;
      num_lo = {ua, {(QUO_W-INT_W){1'b0}}};
      den    = {{(REM_W-INT_W){1'b0}}, ub};
      iters  = CNT_W'(INT_IT);
    end
  end

  div_restoring_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .iters  (iters),
    .num_hi (num_hi),
    .num_lo (num_lo),
    .den    (den),
    .quo    (quo),
    .done   (core_done)
`ifdef INT_FP_DIV_REM_EN
    ,
    .rem    (core_rem)
`endif
  );

  always_comb begin
    c_n    = '0;
    err_n  = 1'b0;
`ifdef INT_FP_DIV_REM_EN
    rem_n  = '0;
`endif
    s_fp   = a_r[15] ^ b_r[15];
    e_fp   = $signed({2'b00, a_r[14:10]}) - $signed({2'b00, b_r[14:10]}) + $signed(7'(BIAS));
    exp_fp = quo[QUO_W-1] ? e_fp : e_fp - 7'sd1;
    frac   = quo[QUO_W-1] ? quo[QUO_W-2:1] : quo[MAN_W-1:0];
    neg_q  = a_r[7] ^ b_r[7];
    q_int  = neg_q ? INT_W'(~quo[INT_W-1:0] + 8'd1) : quo[INT_W-1:0];
    if (mode_r) begin
      if (b_r[14:10] == '0) begin
        c_n   = {s_fp, FP_INF_MAG};
        err_n = 1'b1;
      end else if (a_r[14:10] == '0) begin
        c_n = {s_fp, FP_ZERO_MAG};
      end else if (exp_fp >= $signed(7'(EXP_MAX))) begin
        c_n   = {s_fp, FP_INF_MAG};
        err_n = 1'b1;
      end else if (exp_fp <= 7'sd0) begin
        c_n   = {s_fp, FP_ZERO_MAG};
        err_n = 1'b1;
      end else begin
        c_n = {s_fp, exp_fp[EXP_W-1:0], frac};
      end
    end else begin
      if (b_r[7:0] == '0) begin
        err_n = 1'b1;
      end else if (a_r[7:0] == 8'h80 && b_r[7:0] == 8'hFF) begin
        c_n   = 16'h007F;
        err_n = 1'b1;
      end else begin
        c_n = {{8{q_int[7]}}, q_int};
`ifdef INT_FP_DIV_REM_EN
        rem_n = a_r[7] ? {{8{1'b1}}, 8'(~core_rem + 8'd1)} : {8'h00, core_rem};
        if (core_rem == '0) rem_n = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_r <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      c      <= '0;
      error  <= 1'b0;
`ifdef INT_FP_DIV_REM_EN
      rem    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          mode_r <= mode;
          a_r    <= a;
          b_r    <= b;
          state  <= DIV;
        end
        DIV:  if (core_done) state <= NORM;
        NORM: begin
          c     <= c_n;
          error <= err_n;
`ifdef INT_FP_DIV_REM_EN
          rem   <= rem_n;
`endif
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_fp_div.sv
// Directed self-checking bench for int_fp_div; rem checks compile in with INT_FP_DIV_REM_EN.
module tb_int_fp_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, error;
  logic [15:0] c;
`ifdef INT_FP_DIV_REM_EN
  logic [15:0] rem;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  int_fp_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .error     (error)
`ifdef INT_FP_DIV_REM_EN
    ,
    .rem       (rem)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("idle_before_accept", 32'(in_ready), 32'd1);
    mode = m; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int unsigned lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic m, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ec, input logic ee, input logic [15:0] er);
    int unsigned lat;
    start_op(m, x, y);
    wait_result(lat);
    check({tag, "_lat"}, lat, m ? 32'd14 : 32'd10);
    check({tag, "_c"}, 32'(c), 32'(ec));
    check({tag, "_err"}, 32'(error), 32'(ee));
`ifdef INT_FP_DIV_REM_EN
    check({tag, "_rem"}, 32'(rem), 32'(er));
`else
    if (er != er) check({tag, "_rem"}, 32'd0, 32'd1);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned lat, seen;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("fp_basic",   1'b1, 16'h4200, 16'h4000, 16'h3E00, 1'b0, 16'h0000);
    do_op("fp_third",   1'b1, 16'h3C00, 16'h4200, 16'h3555, 1'b0, 16'h0000);
    do_op("fp_neg",     1'b1, 16'hC000, 16'h3C00, 16'hC000, 1'b0, 16'h0000);
    do_op("fp_div0",    1'b1, 16'h3C00, 16'h0000, 16'h7C00, 1'b1, 16'h0000);
    do_op("fp_zero_a",  1'b1, 16'h0000, 16'hC000, 16'h8000, 1'b0, 16'h0000);
    do_op("fp_ovf",     1'b1, 16'h7800, 16'h0400, 16'h7C00, 1'b1, 16'h0000);
    do_op("fp_unf",     1'b1, 16'h0400, 16'h7800, 16'h0000, 1'b1, 16'h0000);
    do_op("fp_exp31",   1'b1, 16'h7800, 16'h3800, 16'h7C00, 1'b1, 16'h0000);
    do_op("fp_exp30",   1'b1, 16'h7800, 16'h3C00, 16'h7800, 1'b0, 16'h0000);
    do_op("fp_exp1",    1'b1, 16'h0400, 16'h3C00, 16'h0400, 1'b0, 16'h0000);
    do_op("fp_exp0",    1'b1, 16'h0400, 16'h3E00, 16'h0000, 1'b1, 16'h0000);
    do_op("int_neg",    1'b0, 16'h00F9, 16'h0002, 16'hFFFD, 1'b0, 16'hFFFF);
    do_op("int_min_m1", 1'b0, 16'h0080, 16'h00FF, 16'h007F, 1'b1, 16'h0000);
    do_op("int_div0",   1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    do_op("int_upper",  1'b0, 16'h55F9, 16'hC302, 16'hFFFD, 1'b0, 16'hFFFF);
    do_op("int_min_p1", 1'b0, 16'h0080, 16'h0001, 16'hFF80, 1'b0, 16'h0000);
    do_op("int_pos",    1'b0, 16'h007F, 16'h0003, 16'h002A, 1'b0, 16'h0001);

    // Backpressure: result must hold while out_ready is low and inputs are ignored.
    out_ready = 1'b0;
    start_op(1'b0, 16'h00F9, 16'h0002);
    wait_result(lat);
    check("bp_lat", lat, 32'd10);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; mode = i[0]; a = 16'h1234 + 16'(i); b = 16'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_c_hold", 32'(c), 32'hFFFD);
      check("bp_err_hold", 32'(error), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b1; mode = 1'b0; a = 16'h0064; b = 16'h00F9;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_no_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("next_lat", lat, 32'd10);
    check("next_c", 32'(c), 32'hFFF2);
    check("next_err", 32'(error), 32'd0);
`ifdef INT_FP_DIV_REM_EN
    check("next_rem", 32'(rem), 32'h0002);
`endif
    @(posedge clk); #1;

    // Reset during DIV aborts without producing a result.
    start_op(1'b1, 16'h4200, 16'h4000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_stale", seen, 32'd0);
    do_op("after_abort", 1'b1, 16'h3C00, 16'h4200, 16'h3555, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
